// File: rtl/p2_link_rx.sv
// p2_link_rx
// Serial receiver for the player-2 controller link. Recovers five button
// levels from a single idle-high line driven by the slave board and holds
// them until the next good frame, or clears them if the link goes quiet.
//
// Frame, LSB first: start(0), d0=up, d1=down, d2=left, d3=right, d4=attack,
// [even parity over d0..d4], stop(1).
//
// Build option:
//   P2_LINK_PARITY_EN  defined   -> 8-bit frames with a parity bit, checked.
//                      undefined -> 7-bit frames, start/stop checks only.
//   The slave-side transmitter must use the same setting.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   TIMEOUT_CLKS  clk cycles without a good frame before the link is lost
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   rx_in        raw serial line (asynchronous, idles high)
//   btn_up/down/left/right/attack   latched player-2 button levels
//   frame_valid  one-cycle strobe: a good frame has just loaded the buttons
//   frame_err    one-cycle strobe: a frame was rejected (start/parity/stop)
//   link_ok      high while good frames keep arriving within TIMEOUT_CLKS
//
// frame_valid and frame_err are bare strobes with no ready/back-pressure:
// a consumer must act in the single cycle they are high; they are never
// high together.

module p2_link_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int TIMEOUT_CLKS = 2000000
) (
   input  logic clk,
   input  logic reset,
   input  logic rx_in,
   output logic btn_up,
   output logic btn_down,
   output logic btn_left,
   output logic btn_right,
   output logic btn_attack,
   output logic frame_valid,
   output logic frame_err,
   output logic link_ok
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CLKS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef P2_LINK_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t        state, state_d;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    bit_cnt, bit_d;
   logic [4:0]    shift, shift_d;
   logic [4:0]    btn_q;
   logic [TW-1:0] tmo_cnt;
   logic          load_btn, reject;
   logic          par_ok;
`ifdef P2_LINK_PARITY_EN
   logic          par_ok_d;
`else
   assign par_ok = 1'b1;
`endif

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   // All three reset high so a released reset on an idle line is not a start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // FSM state and frame datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
`ifdef P2_LINK_PARITY_EN
         par_ok  <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_cnt <= bit_d;
         shift   <= shift_d;
`ifdef P2_LINK_PARITY_EN
         par_ok  <= par_ok_d;
`endif
      end
   end

   // Next-state and per-frame control. All samples happen when cnt reaches
   // its terminal value, i.e. at mid-bit since START only waits half a bit.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      bit_d    = bit_cnt;
      shift_d  = shift;
`ifdef P2_LINK_PARITY_EN
      par_ok_d = par_ok;
`endif
      load_btn = 1'b0;
      reject   = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_prev && !rx_sync) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_sync) begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end else begin
                  reject  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_sync, shift[4:1]};
               if (bit_cnt == 3'd4) begin
`ifdef P2_LINK_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_cnt + 1'b1;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
`ifdef P2_LINK_PARITY_EN
         S_PARITY: begin
            if (cnt == BIT_LAST) begin
               cnt_d    = '0;
               par_ok_d = (rx_sync == ^shift);
               state_d  = S_STOP;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_d = '0;
               if (rx_sync) begin
                  load_btn = par_ok;
                  reject   = !par_ok;
                  state_d  = S_IDLE;
               end else begin
                  // Low stop bit: framing error or a break. Wait for the line
                  // to recover so a held-low line is not seen as new starts.
                  reject  = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (rx_sync) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Button latch, strobes and link timeout. A good frame in the same cycle
   // as expiry wins. The timeout counter saturates at TIMEOUT_CLKS.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q       <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         link_ok     <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         frame_valid <= load_btn;
         frame_err   <= reject;
         if (load_btn) begin
            btn_q   <= shift;
            link_ok <= 1'b1;
            tmo_cnt <= '0;
         end else begin
            if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt >= TMO_LAST) begin
               btn_q   <= '0;
               link_ok <= 1'b0;
            end
         end
      end
   end

   assign btn_up     = btn_q[0];
   assign btn_down   = btn_q[1];
   assign btn_left   = btn_q[2];
   assign btn_right  = btn_q[3];
   assign btn_attack = btn_q[4];

endmodule

// File: tb/tb_p2_link_rx.sv
// Testbench for p2_link_rx with CLKS_PER_BIT = 16 and TIMEOUT_CLKS = 2000.
// Works with P2_LINK_PARITY_EN defined or undefined; the parity-error
// scenario is only exercised when the macro is defined.

module tb_p2_link_rx;

   localparam int CPB = 16;
   localparam int TMO = 2000;

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   logic rx_in;
   always #5 clk = ~clk;

   logic btn_up, btn_down, btn_left, btn_right, btn_attack;
   logic frame_valid, frame_err, link_ok;
   logic [4:0] btns;
   assign btns = {btn_attack, btn_right, btn_left, btn_down, btn_up};

   p2_link_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_in      (rx_in),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_attack (btn_attack),
      .frame_valid(frame_valid),
      .frame_err  (frame_err),
      .link_ok    (link_ok)
   );

   // scoreboard state
   logic [4:0] exp_q[$];
   logic [4:0] exp_btn;
   int checks = 0;
   int errors = 0;
   int pushed = 0;
   int exp_err = 0;
   int fv_seen = 0;
   int fe_seen = 0;
   int cyc = 0;
   int last_fv_cyc = 0;
   int v0, e0, target;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // output monitor: pops the scoreboard on every frame_valid
   always @(negedge clk) begin
      if (reset) begin
         if (frame_valid || frame_err) chk("fv_fe_exclusive", {31'd0, frame_valid & frame_err}, 0);
         if (frame_valid) begin
            fv_seen++;
            last_fv_cyc = cyc;
            chk("valid_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
               exp_btn = exp_q.pop_front();
               chk("btns_on_valid", {27'd0, btns}, {27'd0, exp_btn});
               chk("link_ok_on_valid", {31'd0, link_ok}, 1);
            end
         end
         if (frame_err) fe_seen++;
      end
   end

   // driver tasks
   task automatic send_bit(input logic b);
      rx_in = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [4:0] d, input bit bad_par, input logic stop);
      if (stop && !bad_par) begin
         exp_q.push_back(d);
         pushed++;
      end else begin
         exp_err++;
      end
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(d[i]);
`ifdef P2_LINK_PARITY_EN
      send_bit((^d) ^ bad_par);
`endif
      send_bit(stop);
   endtask

   initial begin
      reset = 1'b0;
      rx_in = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_btns", {27'd0, btns}, 0);
      chk("rst_fv", {31'd0, frame_valid}, 0);
      chk("rst_fe", {31'd0, frame_err}, 0);
      chk("rst_link", {31'd0, link_ok}, 0);
      reset = 1'b1;
      idle(10);

      // good frame
      v0 = fv_seen;
      send_frame(5'b10101, 1'b0, 1'b1);
      idle(2 * CPB);
      chk("t1_valid_cnt", fv_seen - v0, 1);
      chk("t1_btns", {27'd0, btns}, 5'b10101);
      chk("t1_link", {31'd0, link_ok}, 1);

`ifdef P2_LINK_PARITY_EN
      // parity error
      v0 = fv_seen; e0 = fe_seen;
      send_frame(5'b00011, 1'b1, 1'b1);
      idle(2 * CPB);
      chk("t2_err_cnt", fe_seen - e0, 1);
      chk("t2_valid_cnt", fv_seen - v0, 0);
      chk("t2_btns", {27'd0, btns}, 5'b10101);
`endif

      // start glitch
      v0 = fv_seen; e0 = fe_seen;
      exp_err++;
      rx_in = 1'b0;
      repeat (5) @(negedge clk);
      idle(3 * CPB);
      chk("t3_err_cnt", fe_seen - e0, 1);
      chk("t3_valid_cnt", fv_seen - v0, 0);
      chk("t3_btns", {27'd0, btns}, 5'b10101);

      // framing error followed by a held-low line
      v0 = fv_seen; e0 = fe_seen;
      send_frame(5'b00110, 1'b0, 1'b0);
      rx_in = 1'b0;
      repeat (200) @(negedge clk);
      idle(20);
      chk("t4_err_cnt", fe_seen - e0, 1);
      chk("t4_valid_cnt", fv_seen - v0, 0);
      chk("t4_btns_kept", {27'd0, btns}, 5'b10101);
      send_frame(5'b01000, 1'b0, 1'b1);
      idle(2 * CPB);
      chk("t4_recover_cnt", fv_seen - v0, 1);
      chk("t4_btns_new", {27'd0, btns}, 5'b01000);

      // link timeout: buttons clear exactly TMO cycles after the loading edge
      target = last_fv_cyc + TMO - 1;
      while (cyc < target) @(negedge clk);
      chk("t5_right_before", {31'd0, btn_right}, 1);
      chk("t5_link_before", {31'd0, link_ok}, 1);
      @(negedge clk);
      chk("t5_right_after", {31'd0, btn_right}, 0);
      chk("t5_btns_after", {27'd0, btns}, 0);
      chk("t5_link_after", {31'd0, link_ok}, 0);
      send_frame(5'b01000, 1'b0, 1'b1);
      idle(2 * CPB);
      chk("t5_link_restored", {31'd0, link_ok}, 1);
      chk("t5_btns_restored", {27'd0, btns}, 5'b01000);

      // back-to-back frames with no idle gap
      v0 = fv_seen; e0 = fe_seen;
      for (int i = 0; i < 10; i++) send_frame(5'($urandom_range(0, 31)), 1'b0, 1'b1);
      idle(2 * CPB);
      chk("t6_valid_cnt", fv_seen - v0, 10);
      chk("t6_err_cnt", fe_seen - e0, 0);

      // final report
      chk("queue_empty", exp_q.size(), 0);
      chk("valid_total", fv_seen, pushed);
      chk("err_total", fe_seen, exp_err);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
